// File: rtl/writeback_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : writeback_arbiter
// Purpose  : Shares WB_PORTS register-file/ROB writeback ports among the
//            execution functional units (0 LSU, 1 FP, 2 INT, 3 Branch).
//            Every FU result lands in a one-entry holding register; a
//            rotating-priority arbiter picks up to WB_PORTS held results per
//            cycle and registers them onto the writeback outputs.
// Ports    : clk, rst (async, active-high)
//            flush_valid                 - synchronous pipeline flush
//            fu_valid/dest/data/ticket   - per-FU result bus (packed per FU)
//            fu_ready                    - per-FU accept (back-pressure)
//            wb_valid/dest/data/ticket   - registered writeback per port
//            wb_fu                       - source FU index per port
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int FU_NUMBER      = 4,
  parameter int WB_PORTS       = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int R_ADDR         = 6,
  parameter int ROB_INDEX_BITS = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_valid,
  input  logic [FU_NUMBER-1:0]                fu_valid,
  input  logic [FU_NUMBER*R_ADDR-1:0]         fu_dest,
  input  logic [FU_NUMBER*DATA_WIDTH-1:0]     fu_data,
  input  logic [FU_NUMBER*ROB_INDEX_BITS-1:0] fu_ticket,
  output logic [FU_NUMBER-1:0]                fu_ready,
  output logic [WB_PORTS-1:0]                 wb_valid,
  output logic [WB_PORTS*R_ADDR-1:0]          wb_dest,
  output logic [WB_PORTS*DATA_WIDTH-1:0]      wb_data,
  output logic [WB_PORTS*ROB_INDEX_BITS-1:0]  wb_ticket,
  output logic [WB_PORTS*2-1:0]               wb_fu
);

  localparam int PTR_W = 2;

  // Holding registers, one per FU
  logic [FU_NUMBER-1:0]                     hold_valid;
  logic [FU_NUMBER-1:0][R_ADDR-1:0]         hold_dest;
  logic [FU_NUMBER-1:0][DATA_WIDTH-1:0]     hold_data;
  logic [FU_NUMBER-1:0][ROB_INDEX_BITS-1:0] hold_ticket;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_next;

  // Arbitration results
  logic [FU_NUMBER-1:0]          grant;
  logic [WB_PORTS-1:0]           port_valid;
  logic [WB_PORTS-1:0][PTR_W-1:0] port_fu;
  logic [PTR_W-1:0]              scan_idx;
  int                            grant_cnt;

  // Rotating scan starting at rr_ptr; the n-th valid hold found takes port n.
  // The pointer moves to one past the last granted FU so it gets lowest
  // priority next cycle.
  always_comb begin
    grant     = '0;
    port_valid = '0;
    port_fu   = '0;
    rr_next   = rr_ptr;
    scan_idx  = '0;
    grant_cnt = 0;
    for (int k = 0; k < FU_NUMBER; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr) + k) % FU_NUMBER);
      if (hold_valid[scan_idx] && (grant_cnt < WB_PORTS)) begin
        grant[scan_idx] = 1'b1;
        for (int p = 0; p < WB_PORTS; p++) begin
          if (p == grant_cnt) begin
            port_valid[p] = 1'b1;
            port_fu[p]    = scan_idx;
          end
        end
        rr_next   = PTR_W'((int'(scan_idx) + 1) % FU_NUMBER);
        grant_cnt = grant_cnt + 1;
      end
    end
  end

  // A hold being drained this cycle can be refilled in the same cycle, which
  // gives one result per cycle per FU. During flush every FU may drain freely
  // because whatever it presents is dropped.
  assign fu_ready = flush_valid ? {FU_NUMBER{1'b1}} : (~hold_valid | grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid  <= '0;
      hold_dest   <= '0;
      hold_data   <= '0;
      hold_ticket <= '0;
      rr_ptr      <= '0;
      wb_valid    <= '0;
      wb_dest     <= '0;
      wb_data     <= '0;
      wb_ticket   <= '0;
      wb_fu       <= '0;
    end else if (flush_valid) begin
      // Payload fields are left alone; only the valid bits matter after flush
      hold_valid <= '0;
      wb_valid   <= '0;
      rr_ptr     <= '0;
    end else begin
      for (int i = 0; i < FU_NUMBER; i++) begin
        if (fu_valid[i] && fu_ready[i]) begin
          hold_valid[i]  <= 1'b1;
          hold_dest[i]   <= fu_dest[i*R_ADDR +: R_ADDR];
          hold_data[i]   <= fu_data[i*DATA_WIDTH +: DATA_WIDTH];
          hold_ticket[i] <= fu_ticket[i*ROB_INDEX_BITS +: ROB_INDEX_BITS];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
      rr_ptr <= rr_next;
      for (int p = 0; p < WB_PORTS; p++) begin
        wb_valid[p] <= port_valid[p];
        // Unfilled ports keep their stale payload to avoid needless toggling
        if (port_valid[p]) begin
          wb_dest[p*R_ADDR +: R_ADDR]                 <= hold_dest[port_fu[p]];
          wb_data[p*DATA_WIDTH +: DATA_WIDTH]         <= hold_data[port_fu[p]];
          wb_ticket[p*ROB_INDEX_BITS +: ROB_INDEX_BITS] <= hold_ticket[port_fu[p]];
          wb_fu[p*2 +: 2]                             <= port_fu[p];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_writeback_arbiter
// Purpose  : Directed, table-driven bench for writeback_arbiter plus
//            hand-written sequences for streaming, reset and flush cases.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_writeback_arbiter;

  logic        clk;
  logic        rst;
  logic        flush_valid;
  logic [3:0]  fu_valid;
  logic [23:0] fu_dest;
  logic [127:0] fu_data;
  logic [11:0] fu_ticket;
  logic [3:0]  fu_ready;
  logic [1:0]  wb_valid;
  logic [11:0] wb_dest;
  logic [63:0] wb_data;
  logic [5:0]  wb_ticket;
  logic [3:0]  wb_fu;

  int checks;
  int errors;

  writeback_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .flush_valid (flush_valid),
    .fu_valid    (fu_valid),
    .fu_dest     (fu_dest),
    .fu_data     (fu_data),
    .fu_ticket   (fu_ticket),
    .fu_ready    (fu_ready),
    .wb_valid    (wb_valid),
    .wb_dest     (wb_dest),
    .wb_data     (wb_data),
    .wb_ticket   (wb_ticket),
    .wb_fu       (wb_fu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Payload of FU i for a given tag; distinct per FU and per tag
  function automatic logic [5:0] pdest(input int tag, input int i);
    return 6'(tag * 4 + i);
  endfunction
  function automatic logic [31:0] pdata(input int tag, input int i);
    return 32'hA500_0000 | 32'(tag * 256) | 32'(i);
  endfunction
  function automatic logic [2:0] ptick(input int tag, input int i);
    return 3'(tag + i);
  endfunction

  typedef struct {
    logic       flush;
    logic [3:0] fv;
    int         tag;
    logic [1:0] exp_wbv;
    logic [1:0] exp_fu0;
    logic [1:0] exp_fu1;
    int         exp_tag;
    logic [3:0] exp_ready;
    logic [1:0] exp_rr;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic [3:0] fv, input int tag,
                              input logic [1:0] wbv, input logic [1:0] f0,
                              input logic [1:0] f1, input int etag,
                              input logic [3:0] rdy, input logic [1:0] rr);
    vec_t v;
    v.flush = fl; v.fv = fv; v.tag = tag; v.exp_wbv = wbv; v.exp_fu0 = f0;
    v.exp_fu1 = f1; v.exp_tag = etag; v.exp_ready = rdy; v.exp_rr = rr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] fv, input int tag);
    fu_valid = fv;
    for (int i = 0; i < 4; i++) begin
      fu_dest[i*6 +: 6]     = pdest(tag, i);
      fu_data[i*32 +: 32]   = pdata(tag, i);
      fu_ticket[i*3 +: 3]   = ptick(tag, i);
    end
  endtask

  vec_t vecs[17];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush_valid = 1'b0;
    fu_valid = '0;
    fu_dest = '0;
    fu_data = '0;
    fu_ticket = '0;

    // rr_ptr starts at 3 here: left by the single INT result below
    vecs[0]  = mk(0, 4'b0000, 0, 2'b00, 0, 0, 0, 4'b1111, 2'd3);
    vecs[1]  = mk(0, 4'b0100, 1, 2'b00, 0, 0, 0, 4'b1111, 2'd3);
    vecs[2]  = mk(0, 4'b0000, 0, 2'b01, 2, 0, 1, 4'b1111, 2'd3);
    vecs[3]  = mk(1, 4'b0000, 0, 2'b00, 0, 0, 0, 4'b1111, 2'd0);
    // All four FUs at once from rr_ptr=0
    vecs[4]  = mk(0, 4'b1111, 2, 2'b00, 0, 0, 0, 4'b0011, 2'd0);
    vecs[5]  = mk(0, 4'b0000, 0, 2'b11, 0, 1, 2, 4'b1111, 2'd2);
    vecs[6]  = mk(0, 4'b0000, 0, 2'b11, 2, 3, 2, 4'b1111, 2'd0);
    vecs[7]  = mk(0, 4'b0000, 0, 2'b00, 0, 0, 0, 4'b1111, 2'd0);
    // Walk rr_ptr to 3, then holds 1001 -> FU3 on port0, FU0 on port1
    vecs[8]  = mk(0, 4'b0111, 3, 2'b00, 0, 0, 0, 4'b1011, 2'd0);
    vecs[9]  = mk(0, 4'b0000, 0, 2'b11, 0, 1, 3, 4'b1111, 2'd2);
    vecs[10] = mk(0, 4'b0000, 0, 2'b01, 2, 0, 3, 4'b1111, 2'd3);
    vecs[11] = mk(0, 4'b1001, 4, 2'b00, 0, 0, 0, 4'b1111, 2'd3);
    vecs[12] = mk(0, 4'b0000, 0, 2'b11, 3, 0, 4, 4'b1111, 2'd1);
    // Fill all holds, then flush with an FP result presented
    vecs[13] = mk(0, 4'b1111, 5, 2'b00, 0, 0, 0, 4'b0110, 2'd1);
    vecs[14] = mk(1, 4'b0010, 6, 2'b00, 0, 0, 0, 4'b1111, 2'd0);
    vecs[15] = mk(0, 4'b0000, 0, 2'b00, 0, 0, 0, 4'b1111, 2'd0);
    vecs[16] = mk(0, 4'b0000, 0, 2'b00, 0, 0, 0, 4'b1111, 2'd0);

    // ---- reset then idle ----
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_wb_valid", 64'(wb_valid), 64'h0);
    chk("reset_wb_payload", 64'(wb_dest) ^ wb_data ^ 64'(wb_ticket) ^ 64'(wb_fu), 64'h0);
    chk("reset_wb_data", wb_data, 64'h0);
    chk("reset_fu_ready", 64'(fu_ready), 64'hF);
    chk("reset_rr_ptr", 64'(dut.rr_ptr), 64'h0);

    // ---- single INT result ----
    fu_valid = 4'b0100;
    fu_dest[2*6 +: 6] = 6'd5;
    fu_data[2*32 +: 32] = 32'hDEADBEEF;
    fu_ticket[2*3 +: 3] = 3'd3;
    @(posedge clk); #1;
    fu_valid = '0;
    chk("int_wait_wb_valid", 64'(wb_valid), 64'h0);
    @(posedge clk); #1;
    chk("int_wb_valid", 64'(wb_valid), 64'h1);
    chk("int_wb_dest", 64'(wb_dest[5:0]), 64'd5);
    chk("int_wb_data", 64'(wb_data[31:0]), 64'hDEADBEEF);
    chk("int_wb_ticket", 64'(wb_ticket[2:0]), 64'd3);
    chk("int_wb_fu", 64'(wb_fu[1:0]), 64'd2);

    // ---- table ----
    for (int n = 0; n < 17; n++) begin
      flush_valid = vecs[n].flush;
      drive(vecs[n].fv, vecs[n].tag);
      @(posedge clk); #1;
      flush_valid = 1'b0;
      fu_valid = '0;
      #1;
      chk($sformatf("v%0d_wb_valid", n), 64'(wb_valid), 64'(vecs[n].exp_wbv));
      chk($sformatf("v%0d_fu_ready", n), 64'(fu_ready), 64'(vecs[n].exp_ready));
      chk($sformatf("v%0d_rr_ptr", n), 64'(dut.rr_ptr), 64'(vecs[n].exp_rr));
      for (int p = 0; p < 2; p++) begin
        if (vecs[n].exp_wbv[p]) begin
          int f;
          f = (p == 0) ? int'(vecs[n].exp_fu0) : int'(vecs[n].exp_fu1);
          chk($sformatf("v%0d_p%0d_fu", n, p), 64'(wb_fu[p*2 +: 2]), 64'(f));
          chk($sformatf("v%0d_p%0d_dest", n, p), 64'(wb_dest[p*6 +: 6]),
              64'(pdest(vecs[n].exp_tag, f)));
          chk($sformatf("v%0d_p%0d_data", n, p), 64'(wb_data[p*32 +: 32]),
              64'(pdata(vecs[n].exp_tag, f)));
          chk($sformatf("v%0d_p%0d_ticket", n, p), 64'(wb_ticket[p*3 +: 3]),
              64'(ptick(vecs[n].exp_tag, f)));
        end
      end
    end
    chk("flush_holds_empty", 64'(dut.hold_valid), 64'h0);

    // ---- back-to-back FU2 stream, data 1..4 ----
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        fu_valid = 4'b0100;
        fu_data[2*32 +: 32] = 32'(k + 1);
      end else begin
        fu_valid = '0;
      end
      #1;
      if (k < 4) chk($sformatf("stream_ready_%0d", k), 64'(fu_ready[2]), 64'h1);
      @(posedge clk); #1;
      if (k >= 1) begin
        chk($sformatf("stream_valid_%0d", k), 64'(wb_valid[0]), 64'h1);
        chk($sformatf("stream_data_%0d", k), 64'(wb_data[31:0]), 64'(k));
      end
    end
    fu_valid = '0;
    @(posedge clk); #1;

    // ---- async reset mid-operation discards held results ----
    drive(4'b1111, 7);
    @(posedge clk); #1;
    fu_valid = '0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_holds", 64'(dut.hold_valid), 64'h0);
    chk("midrst_wb_valid", 64'(wb_valid), 64'h0);
    chk("midrst_rr_ptr", 64'(dut.rr_ptr), 64'h0);
    chk("midrst_fu_ready", 64'(fu_ready), 64'hF);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_no_wb", 64'(wb_valid), 64'h0);

    // ---- flush and reset together ----
    drive(4'b1111, 2);
    @(posedge clk); #1;
    fu_valid = '0;
    flush_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    flush_valid = 1'b0;
    #1;
    chk("flushrst_holds", 64'(dut.hold_valid), 64'h0);
    chk("flushrst_rr_ptr", 64'(dut.rr_ptr), 64'h0);
    chk("flushrst_wb_valid", 64'(wb_valid), 64'h0);
    @(posedge clk); #1;
    chk("flushrst_no_wb", 64'(wb_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
